// File: rtl/data_mem_scheduler_pkg.sv
// data_mem_scheduler_pkg: addressing codes, dump FSM states and read-owner tag shared by the memory front end.
package data_mem_scheduler_pkg;

    localparam logic [1:0] ADDR_BYTE    = 2'b00;
    localparam logic [1:0] ADDR_HALF    = 2'b01;
    localparam logic [1:0] ADDR_ILLEGAL = 2'b10;
    localparam logic [1:0] ADDR_WORD    = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } dump_state_t;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_DUMP = 1'b1
    } owner_t;

endpackage

// File: rtl/data_mem_scheduler_align_check.sv
// mem_align_check: flags accesses whose byte address does not fit the requested size.
module mem_align_check
    import data_mem_scheduler_pkg::*;
#(
    parameter int NB_ADDRESS = 6
) (
    input  logic [NB_ADDRESS-1:0] addr,
    input  logic [1:0]            addressing,
    output logic                  misaligned
);

    assign misaligned = (addressing == ADDR_ILLEGAL)
                      | ((addressing == ADDR_HALF) & (|(addr & NB_ADDRESS'(1))))
                      | ((addressing == ADDR_WORD) & (|(addr & NB_ADDRESS'(3))));

endmodule

// File: rtl/data_mem_scheduler.sv
// data_mem_scheduler: shares combined_memory between the MEM stage (always first) and a debug word-dump engine.
module data_mem_scheduler
    import data_mem_scheduler_pkg::*;
#(
    parameter int NB_DATA_BUS = 32,
    parameter int NB_ADDRESS  = 6,
    parameter int NB_COUNT    = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_pipe_r_en,
    input  logic                   i_pipe_w_en,
    input  logic [NB_ADDRESS-1:0]  i_pipe_addr,
    input  logic [1:0]             i_pipe_addressing,
    input  logic [NB_DATA_BUS-1:0] i_pipe_w_data,
    output logic [NB_DATA_BUS-1:0] o_pipe_r_data,
    output logic                   o_pipe_r_valid,
    output logic                   o_pipe_misaligned,
    input  logic                   i_dump_start,
    input  logic [NB_ADDRESS-1:0]  i_dump_base,
    input  logic [NB_COUNT-1:0]    i_dump_words,
    output logic [NB_DATA_BUS-1:0] o_dump_data,
    output logic                   o_dump_valid,
    input  logic                   i_dump_ready,
    output logic                   o_dump_busy,
    output logic                   o_dump_done,
    output logic                   o_mem_r_en,
    output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
    output logic [1:0]             o_mem_r_addressing,
    output logic                   o_mem_w_en,
    output logic [NB_ADDRESS-1:0]  o_mem_w_addr,
    output logic [NB_DATA_BUS-1:0] o_mem_w_data,
    output logic [1:0]             o_mem_w_addressing,
    input  logic [NB_DATA_BUS-1:0] i_mem_r_data
);

    dump_state_t            state, state_next;
    owner_t                 owner;
    logic                   misaligned, pipe_req, pipe_rd, pipe_wr, dump_rd, rd_pending;
    logic [NB_ADDRESS-1:0]  dump_addr, dump_addr_next;
    logic [NB_COUNT-1:0]    cnt, cnt_next;
    logic [NB_DATA_BUS-1:0] dump_data, dump_data_next;

    mem_align_check #(.NB_ADDRESS(NB_ADDRESS)) align_check (
        .addr       (i_pipe_addr),
        .addressing (i_pipe_addressing),
        .misaligned (misaligned)
    );

    assign pipe_req = i_pipe_r_en | i_pipe_w_en;
    assign pipe_rd  = i_pipe_r_en & ~misaligned;
    assign pipe_wr  = i_pipe_w_en & ~misaligned;
    // The dump yields to any pipeline request, even a rejected one, so it never races the MEM stage.
    assign dump_rd  = (state == ISSUE) & ~pipe_req;

    assign o_pipe_misaligned  = pipe_req & misaligned;
    assign o_mem_r_en         = pipe_rd | dump_rd;
    assign o_mem_r_addr       = dump_rd ? dump_addr : i_pipe_addr;
    assign o_mem_r_addressing = dump_rd ? ADDR_WORD : i_pipe_addressing;
    assign o_mem_w_en         = pipe_wr;
    assign o_mem_w_addr       = i_pipe_addr;
    assign o_mem_w_data       = i_pipe_w_data;
    assign o_mem_w_addressing = i_pipe_addressing;

    assign o_pipe_r_valid = rd_pending & (owner == OWN_PIPE);
    assign o_pipe_r_data  = o_pipe_r_valid ? i_mem_r_data : '0;
    assign o_dump_data    = dump_data;
    assign o_dump_valid   = state == HOLD;
    assign o_dump_busy    = state != IDLE;
    assign o_dump_done    = state == DONE;

    always_comb begin
        state_next     = state;
        dump_addr_next = dump_addr;
        cnt_next       = cnt;
        dump_data_next = dump_data;
        unique case (state)
            IDLE: begin
                if (i_dump_start) begin
                    state_next     = (i_dump_words != '0) ? ISSUE : DONE;
                    dump_addr_next = i_dump_base & ~NB_ADDRESS'(3);
                    cnt_next       = i_dump_words;
                end
            end
            ISSUE: state_next = dump_rd ? WAIT : ISSUE;
            WAIT: begin
                dump_data_next = i_mem_r_data;
                state_next     = HOLD;
            end
            HOLD: begin
                if (i_dump_ready) begin
                    dump_addr_next = dump_addr + NB_ADDRESS'(4);
                    cnt_next       = cnt - NB_COUNT'(1);
                    state_next     = (cnt == NB_COUNT'(1)) ? DONE : ISSUE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            owner      <= OWN_PIPE;
            rd_pending <= 1'b0;
            dump_addr  <= '0;
            cnt        <= '0;
            dump_data  <= '0;
        end else begin
            state      <= state_next;
            owner      <= dump_rd ? OWN_DUMP : OWN_PIPE;
            rd_pending <= o_mem_r_en;
            dump_addr  <= dump_addr_next;
            cnt        <= cnt_next;
            dump_data  <= dump_data_next;
        end
    end

endmodule
